full_adder: RTL and testbench

- Combinational full adder (a + b + cin -> sum, cout) with an optional registered copy of the result.
- Leaf arithmetic block used wherever a bit-level or narrow add-with-carry is needed.
- The combinational path needs no clock and must work even when clk/resetn are left undriven.
- The registered path provides a timing-closed version for pipelined users.

---
 rtl/fa_cell.sv | 13 +
 rtl/full_adder.sv | 55 +++++
 tb/tb_full_adder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fa_cell.sv
// One-bit full adder cell; the ripple-carry building block of full_adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with carry in/out, plus a registered copy of the
// result for pipelined users. The combinational outputs never depend on clk/resetn.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             en,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign c[0] = cin;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        fa_cell u_cell (
            .a   (a[g]),
            .b   (b[g]),
            .cin (c[g]),
            .sum (sum[g]),
            .cout(c[g+1])
        );
    end

    assign cout = c[WIDTH];

    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        if (en) begin
            sum_d  = sum;
            cout_d = cout;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: truth table, WIDTH=4 corners, random combinational and
// registered traffic against an arithmetic reference, and async reset behaviour.
module tb_full_adder;

    logic clk, clk_run, resetn;

    logic       a1, b1, cin1, en1;
    logic       sum1, cout1, sum1_q, cout1_q;
    logic [3:0] a4, b4, sum4, sum4_q;
    logic       cin4, en4, cout4, cout4_q;
    logic [7:0] a8, b8, sum8, sum8_q;
    logic       cin8, en8, cout8, cout8_q;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic a, b, cin;
        logic s, co;
    } vec1_t;

    typedef struct {
        logic [3:0] a, b;
        logic       cin;
        logic [3:0] s;
        logic       co;
    } vec4_t;

    vec1_t tt[8];
    vec4_t t4[3];

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .resetn(resetn), .a(a1), .b(b1), .cin(cin1), .en(en1),
        .sum(sum1), .cout(cout1), .sum_q(sum1_q), .cout_q(cout1_q)
    );
    full_adder #(.WIDTH(4)) u4 (
        .clk(clk), .resetn(resetn), .a(a4), .b(b4), .cin(cin4), .en(en4),
        .sum(sum4), .cout(cout4), .sum_q(sum4_q), .cout_q(cout4_q)
    );
    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .resetn(resetn), .a(a8), .b(b8), .cin(cin8), .en(en8),
        .sum(sum8), .cout(cout8), .sum_q(sum8_q), .cout_q(cout8_q)
    );

    // Clock only toggles while clk_run is set, so reset can be checked with no edges.
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [8:0] ref8;
        logic [4:0] ref4;
        logic [4:0] exp4_q;

        clk = 0; clk_run = 0; resetn = 0;
        a1 = 0; b1 = 0; cin1 = 0; en1 = 0;
        a4 = 0; b4 = 0; cin4 = 0; en4 = 0;
        a8 = 0; b8 = 0; cin8 = 0; en8 = 0;

        for (int i = 0; i < 8; i++) begin
            tt[i].a   = i[2];
            tt[i].b   = i[1];
            tt[i].cin = i[0];
        end
        tt[0].s = 0; tt[1].s = 1; tt[2].s = 1; tt[3].s = 0;
        tt[4].s = 1; tt[5].s = 0; tt[6].s = 0; tt[7].s = 1;
        tt[0].co = 0; tt[1].co = 0; tt[2].co = 0; tt[3].co = 1;
        tt[4].co = 0; tt[5].co = 1; tt[6].co = 1; tt[7].co = 1;

        t4[0] = '{a: 4'hF, b: 4'h1, cin: 1'b0, s: 4'h0, co: 1'b1};
        t4[1] = '{a: 4'h7, b: 4'h8, cin: 1'b1, s: 4'h0, co: 1'b1};
        t4[2] = '{a: 4'h3, b: 4'h4, cin: 1'b0, s: 4'h7, co: 1'b0};

        // Reset state with no clock running
        #2;
        chk("reset_sum_q", {31'd0, sum1_q}, 0);
        chk("reset_cout_q", {31'd0, cout1_q}, 0);
        chk("reset_sum4_q", {27'd0, cout4_q, sum4_q}, 0);

        // WIDTH=1 truth table, works while resetn is low
        for (int i = 0; i < 8; i++) begin
            a1 = tt[i].a; b1 = tt[i].b; cin1 = tt[i].cin;
            #5;
            chk($sformatf("tt%0d_sum", i), {31'd0, sum1}, {31'd0, tt[i].s});
            chk($sformatf("tt%0d_cout", i), {31'd0, cout1}, {31'd0, tt[i].co});
        end

        a1 = 1; b1 = 0; cin1 = 1; #1;
        chk("default_vec", {30'd0, cout1, sum1}, 32'd2);

        a1 = 1; b1 = 1; cin1 = 0; #1;
        chk("indep_comb", {30'd0, cout1, sum1}, 32'd2);
        chk("indep_reg", {30'd0, cout1_q, sum1_q}, 0);

        // WIDTH=4 corners including all-ones + all-ones + 1 and all zeros
        for (int i = 0; i < 3; i++) begin
            a4 = t4[i].a; b4 = t4[i].b; cin4 = t4[i].cin;
            #1;
            chk($sformatf("w4_%0d", i), {27'd0, cout4, sum4}, {27'd0, t4[i].co, t4[i].s});
        end
        a4 = 4'hF; b4 = 4'hF; cin4 = 1; #1;
        chk("w4_all_ones", {27'd0, cout4, sum4}, {27'd0, 1'b1, 4'hF});
        a4 = 0; b4 = 0; cin4 = 0; #1;
        chk("w4_all_zero", {27'd0, cout4, sum4}, 0);

        // Random combinational traffic on the WIDTH=8 instance
        for (int i = 0; i < 60; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            #1;
            ref8 = 9'(a8) + 9'(b8) + 9'(cin8);
            chk("w8_rand", {23'd0, cout8, sum8}, {23'd0, ref8});
        end

        // Release reset between edges with en=0: nothing captured yet
        clk_run = 1;
        @(negedge clk);
        resetn = 1; en1 = 0; a1 = 1; b1 = 1; cin1 = 1;
        @(posedge clk); #1;
        chk("no_capture_en0", {30'd0, cout1_q, sum1_q}, 0);

        @(negedge clk); en1 = 1;
        @(posedge clk); #1;
        chk("capture_111", {30'd0, cout1_q, sum1_q}, 32'd3);

        @(negedge clk); en1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_en0", {30'd0, cout1_q, sum1_q}, 32'd3);
        chk("comb_after_hold", {30'd0, cout1, sum1}, 0);

        // Async reset mid-cycle, checked well before the next edge
        @(negedge clk); #1;
        resetn = 0; #1;
        chk("async_reset", {30'd0, cout1_q, sum1_q}, 0);
        @(negedge clk); resetn = 1;

        // Random registered traffic on WIDTH=4 with random enable
        exp4_q = 0;
        @(negedge clk); resetn = 0; #1; resetn = 1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            en4 = ($urandom_range(0, 3) != 0);
            ref4 = 5'(a4) + 5'(b4) + 5'(cin4);
            if (en4) exp4_q = ref4;
            @(posedge clk); #1;
            chk("w4_reg_rand", {27'd0, cout4_q, sum4_q}, {27'd0, exp4_q});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
